// File: rtl/snn_input_loader.sv
// Receives a packed 28x28 binary image byte by byte, unpacks it LSB-first into
// a 784x1 pixel memory, then hands the image to the SNN core and serves its reads.
module snn_input_loader #(
  parameter int N_PIXELS = 784,
  parameter int N_BYTES  = 98
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rx_rdy,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       start,
  input  logic       core_done,
  output logic       busy,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    UNPACK    = 2'd1,
    START     = 2'd2,
    WAIT_CORE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sreg_q, sreg_d;
  logic       busy_q, busy_d;
  logic       q_q;
  logic       mem_we;
  logic       clr_c;
  logic [9:0] wr_addr;

  logic mem [N_PIXELS];

  // Pixel address is byte_cnt*8 + bit_cnt, which is just the concatenation.
  assign wr_addr = {byte_cnt_q, bit_cnt_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sreg_q     <= sreg_d;
      busy_q     <= busy_d;
    end
  end

  // Receiver handshake: rx_rdy is a level meaning a byte is pending on rx_data;
  // clr_rx_rdy is high for the single cycle in which that byte is consumed, and
  // the byte counts as taken on the rising edge that ends that cycle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    busy_d     = busy_q;
    clr_c      = 1'b0;
    start      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      LOAD: begin
        if (rx_rdy) begin
          clr_c   = 1'b1;
          sreg_d  = rx_data;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        mem_we    = 1'b1;
        sreg_d    = {1'b0, sreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          if (byte_cnt_q == 7'(N_BYTES - 1)) begin
            state_d = START;
          end else begin
            byte_cnt_d = byte_cnt_q + 7'd1;
            state_d    = LOAD;
          end
        end
      end
      START: begin
        start      = 1'b1;
        byte_cnt_d = '0;
        state_d    = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done) begin
          busy_d  = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Never consume a pending byte while reset holds the machine.
  assign clr_rx_rdy = clr_c & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= sreg_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= (addr_input_unit < 10'(N_PIXELS)) ? mem[addr_input_unit] : 1'b0;
  end

  assign q_input = q_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule
